// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV-M funct3 ops,
// FSM states and the position of the word-variant bit in the op field.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int OP_W = 3;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per step_i.
// Dividend must arrive MSB-aligned so narrow operands finish in fewer steps.
module mdu_div_core
   import mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] dvd_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o
);

   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // The shifted partial remainder can reach 2*divisor, hence the extra bit;
   // the borrow out of diff decides both the quotient bit and the restore.
   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
      rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (load_i) begin
         quo_q <= dvd_i;
         rem_q <= '0;
         dvs_q <= dvs_i;
      end else if (step_i) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV-M multiply/divide: result N+1 cycles after accept (1 for div-by-0/overflow),
// held in DONE until out_ready; flush aborts. W ops compiled only with MDU_WORD_OPS_EN.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   function automatic logic word_of(input logic [3:0] o);
`ifdef MDU_WORD_OPS_EN
      return o[OP_W] && (XLEN == 64);
`else
      return o[OP_W] & 1'b0;
`endif
   endfunction

   function automatic logic s1_sgn(input logic [2:0] f);
      return op_e'(f) == OP_MULH || op_e'(f) == OP_MULHSU ||
             op_e'(f) == OP_DIV  || op_e'(f) == OP_REM;
   endfunction

   function automatic logic s2_sgn(input logic [2:0] f);
      return op_e'(f) == OP_MULH || op_e'(f) == OP_DIV || op_e'(f) == OP_REM;
   endfunction

   function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic w,
                                          input logic sg);
      logic [XLEN-1:0] r;
      r = v;
      if (w) begin
         for (int i = 32; i < XLEN; i++) r[i] = sg & v[31];
      end
      return r;
   endfunction

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic                out_valid_q;
   logic [XLEN-1:0]     result_q;
   logic [3:0]          op_q;
   logic [XLEN-1:0]     src1_q, src2_q;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [XLEN-1:0]     quo, rem;

   logic                accept, step;

   // Accept-side decode, taken straight from the request inputs
   logic                in_w, in_s1, in_s2, in_n1, in_n2;
   logic [XLEN-1:0]     in_a, in_b, abs_a, abs_b, dvd_ld;

   // Decode of the latched request, used during BUSY
   logic                w_r, s1_r, s2_r, n1_r, n2_r, special;
   logic [2:0]          f_r;
   logic [XLEN-1:0]     a_r, b_r, min_neg;
   logic [CW-1:0]       n_iter;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     quo_s, rem_s, fin_raw, fin, spec_raw, spec;

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign step      = (state_q == ST_BUSY) && (cnt_q != n_iter);
   assign out_valid = out_valid_q;
   assign result    = result_q;

   always_comb begin
      in_w   = word_of(op);
      in_s1  = s1_sgn(op[2:0]);
      in_s2  = s2_sgn(op[2:0]);
      in_a   = ext(src1, in_w, in_s1);
      in_b   = ext(src2, in_w, in_s2);
      in_n1  = in_s1 & in_a[XLEN-1];
      in_n2  = in_s2 & in_b[XLEN-1];
      abs_a  = in_n1 ? -in_a : in_a;
      abs_b  = in_n2 ? -in_b : in_b;
      dvd_ld = in_w ? (abs_a << (XLEN - 32)) : abs_a;
   end

   always_comb begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
   end

   always_comb begin
      w_r    = word_of(op_q);
      f_r    = op_q[2:0];
      s1_r   = s1_sgn(f_r);
      s2_r   = s2_sgn(f_r);
      a_r    = ext(src1_q, w_r, s1_r);
      b_r    = ext(src2_q, w_r, s2_r);
      n1_r   = s1_r & a_r[XLEN-1];
      n2_r   = s2_r & b_r[XLEN-1];
      n_iter = w_r ? CW'(32) : CW'(XLEN);

      min_neg           = '0;
      min_neg[XLEN-1]   = 1'b1;
      if (w_r) begin
         for (int i = 31; i < XLEN; i++) min_neg[i] = 1'b1;
      end
      special = op_q[2] && ((b_r == '0) || (s2_r && a_r == min_neg && b_r == '1));

      if (b_r == '0) spec_raw = f_r[1] ? a_r : '1;
      else           spec_raw = f_r[1] ? '0  : a_r;
      spec = ext(spec_raw, w_r, 1'b1);

      prod_s = (n1_r ^ n2_r) ? -prod_q : prod_q;
      quo_s  = (n1_r ^ n2_r) ? -quo : quo;
      rem_s  = n1_r ? -rem : rem;
      if (op_q[2])                          fin_raw = f_r[1] ? rem_s : quo_s;
      else if (op_e'(f_r) == OP_MUL || w_r) fin_raw = prod_s[XLEN-1:0];
      else                                  fin_raw = prod_s[2*XLEN-1:XLEN];
      fin = ext(fin_raw, w_r, 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (accept) begin
         op_q     <= op;
         src1_q   <= src1;
         src2_q   <= src2;
         prod_q   <= '0;
         mcand_q  <= {{XLEN{1'b0}}, abs_a};
         mplier_q <= abs_b;
      end else if (step) begin
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   mdu_div_core #(.XLEN(XLEN)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .step_i (step),
      .dvd_i  (dvd_ld),
      .dvs_i  (abs_b),
      .quo_o  (quo),
      .rem_o  (rem)
   );

   // Counter 0 is the decision cycle for the no-iteration divide cases;
   // reaching n_iter means all N steps have been applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_BUSY;
                  cnt_q   <= '0;
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0 && special) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= spec;
               end else if (cnt_q == n_iter) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= fin;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= accept ? ST_BUSY : ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=64): hand-computed results and latencies,
// backpressure, flush and mid-operation reset.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [63:0] src1, src2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mdu_iter #(.XLEN(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_r, input int exp_lat);
      int lat;
      int w;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b1;
      op       = o;
      src1     = a;
      src2     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 200);
      chk({tag, " res"}, result, exp_r);
      chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
   endtask

   task automatic watch_quiet(input string tag);
      logic seen;
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      chk(tag, {63'd0, seen}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 4'd0;
      src1      = '0;
      src2      = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst result",    result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul 7*-3",     4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      run_op("mulhu ones",   4'b0011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_op("div 5/0",      4'b0100, 64'd5, 64'd0, '1, 1);
      run_op("rem 5/0",      4'b0110, 64'd5, 64'd0, 64'd5, 1);
      run_op("div ovf",      4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
      run_op("rem ovf",      4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
      run_op("div -7/2",     4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("rem -7/2",     4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
      run_op("mulh -2*3",    4'b0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, '1, 65);
      run_op("mulhsu -1*2",  4'b0010, '1, 64'd2, '1, 65);
      run_op("mulhu 2^63*4", 4'b0011, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65);
      run_op("mulh min*min", 4'b0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             64'h4000_0000_0000_0000, 65);
      run_op("div min/2",    4'b0100, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 65);
      run_op("divu 2^63/-1", 4'b0101, 64'h8000_0000_0000_0000, '1, 64'd0, 65);
      run_op("remu 2^63/-1", 4'b0111, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65);
      run_op("remu 100/7",   4'b0111, 64'd100, 64'd7, 64'd2, 65);
`ifdef MDU_WORD_OPS_EN
      run_op("divw",         4'b1100, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 33);
      run_op("mulw via mulh", 4'b1001, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
`else
      run_op("div op3 ignored", 4'b1100, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'h0000_0000_7FFF_FFFC, 65);
      run_op("mulh op3 ignored", 4'b1001, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'd0, 65);
`endif

      // Let the last result drain, then stall the consumer
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      run_op("bp divu 100/7", 4'b0101, 64'd100, 64'd7, 64'd14, 65);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("bp result",    result, 64'd14);
         chk("bp out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp in_ready",  {63'd0, in_ready},  64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk("bp drained", {63'd0, out_valid}, 64'd0);

      @(negedge clk);
      in_valid = 1'b1;
      op       = 4'b0000;
      src1     = 64'd9;
      src2     = 64'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("busy in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush in_ready",  {63'd0, in_ready},  64'd1);
      watch_quiet("flush no result");

      @(negedge clk);
      in_valid = 1'b1;
      op       = 4'b0000;
      src1     = 64'd11;
      src2     = 64'd11;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst in_ready",  {63'd0, in_ready},  64'd1);
      chk("midrst result",    result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_quiet("midrst no result");

      run_op("mul after rst", 4'b0000, 64'd3, 64'd5, 64'd15, 65);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64; datapath width (32 or 64).
REQ-002 SHALL have port clk, input, 1; sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 1; request present.
REQ-005 SHALL have port in_ready, output, 1; block can accept a request.
REQ-006 SHALL have port op, input, 4; op[2:0] = RV M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); op[3] = word (W) variant.
REQ-007 SHALL have port src1, input, XLEN; rs1 operand.
REQ-008 SHALL have port src2, input, XLEN; rs2 operand.
REQ-009 SHALL have port flush, input, 1; abort in-flight op.
REQ-010 SHALL have port out_valid, output, 1; result present.
REQ-011 SHALL have port out_ready, input, 1; consumer accepts result.
REQ-012 SHALL have port result, output, XLEN; RV-M-compliant result.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 SHALL assert in_ready only in IDLE, or in DONE when out_ready=1 (back-to-back accept).
REQ-015 SHALL latch op/src1/src2 on the edge where in_valid & in_ready, entering BUSY.
REQ-016 SHALL multiply by radix-2 shift-add over |operands|, then sign-correct; N iterations, N = XLEN, or 32 for word ops.
REQ-017 SHALL divide by restoring shift-subtract on |operands|, then sign-correct quotient (sign1^sign2) and remainder (sign of dividend); N iterations.
REQ-018 SHALL raise out_valid exactly N+1 cycles after the accepting edge.
REQ-019 SHALL resolve divisor==0 with no iteration: quotient = all ones, remainder = dividend; out_valid 1 cycle after accept.
REQ-020 SHALL resolve signed overflow (most-negative / -1) with no iteration: quotient = dividend, remainder = 0; out_valid 1 cycle after accept.
REQ-021 SHALL hold result and out_valid stable in DONE while out_ready=0.
REQ-022 SHALL return to IDLE on the edge where out_valid & out_ready, unless a new request is accepted on the same edge (then BUSY).
REQ-023 SHALL, on flush=1, enter IDLE at the next edge, drop any result, and keep out_valid low; flush overrides in_valid and out_ready in the same cycle.
REQ-024 SHALL select the high XLEN bits of the 2*XLEN product for MULH/MULHSU/MULHU and the low bits for MUL.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, out_valid=0, in_ready=1, result=0, iteration counter=0.
REQ-026 SHALL, on reset mid-operation, discard the operation; no result is ever presented for it.

Configuration
REQ-027 SHALL compile W variants when macro MDU_WORD_OPS_EN is defined and XLEN=64: operate on src[31:0]; result = sign-extended 32-bit result; op[3] with op[2:0] in {1,2,3} executes as MULW.
REQ-028 SHALL, without MDU_WORD_OPS_EN, ignore op[3] and execute the full-width op.

Structure
REQ-029 SHALL place the op encoding enum, FSM state enum and the OP_W bit index in shared package mdu_pkg.
REQ-030 SHALL implement the iterative divider as sub-module mdu_div_core; the multiplier and FSM stay in mdu_iter.

Verification (XLEN=64)
REQ-031 SHALL check MUL src1=7, src2=-3 -> result 0xFFFFFFFFFFFFFFEB, out_valid 65 cycles after accept.
REQ-032 SHALL check MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE.
REQ-033 SHALL check DIV 5/0 -> 0xFFFFFFFFFFFFFFFF and REM 5/0 -> 5, each 1 cycle after accept; DIV 0x8000000000000000/-1 -> 0x8000000000000000, REM -> 0.
REQ-034 SHALL check DIV -7/2 -> -3 and REM -7/2 -> -1, N+1 latency.
REQ-035 SHALL check out_ready held low 3 cycles in DONE -> result stable, in_ready low; flush at cycle 10 of BUSY -> no out_valid, in_ready=1 next cycle.
REQ-036 SHALL check, with MDU_WORD_OPS_EN, DIVW src1=0x00000000FFFFFFF8, src2=2 -> 0xFFFFFFFFFFFFFFFC, out_valid 33 cycles after accept.
